// File: rtl/mips150_fetch_if.sv
// mips150_fetch_if: hazard/redirect inputs, IMEM port B and X-stage outputs of the fetch stage
interface mips150_fetch_if #(
   parameter int IMEM_AW = 12
);
   logic               stall;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               imem_en;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic [31:0]        instr_x;
   logic [31:0]        pc_x;
   logic               valid_x;
   modport master (
      input  stall, redirect_valid, redirect_pc, imem_rdata,
      output imem_en, imem_addr, instr_x, pc_x, valid_x
   );
   modport slave (
      output stall, redirect_valid, redirect_pc, imem_rdata,
      input  imem_en, imem_addr, instr_x, pc_x, valid_x
   );
endinterface

// File: rtl/mips150_fetch_stage.sv
// mips150_fetch_stage: PC, IMEM port B fetch, delay-slot redirect handling and the I-X pipeline register
module mips150_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          IMEM_AW   = 12,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input logic             clk,
   input logic             rst_n,
   mips150_fetch_if.master bus
);
   typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;
   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] resp_pc_q, resp_pc_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] instr_x_q, instr_x_d;
   logic [31:0] pc_x_q, pc_x_d;
   logic        valid_x_q, valid_x_d;
   logic        redir;
   logic [31:0] tgt;
   assign bus.imem_en   = rst_n & ~bus.stall;
   assign bus.imem_addr = fetch_pc_q[IMEM_AW+1:2];
   assign bus.instr_x   = instr_x_q;
   assign bus.pc_x      = pc_x_q;
   assign bus.valid_x   = valid_x_q;
   // state and pipeline registers; async reset discards any in-flight fetch and pending redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         fetch_pc_q   <= RESET_PC;
         resp_pc_q    <= RESET_PC;
         resp_valid_q <= 1'b0;
         pend_pc_q    <= RESET_PC;
         pend_valid_q <= 1'b0;
         instr_x_q    <= NOP_INSTR;
         pc_x_q       <= RESET_PC;
         valid_x_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         resp_pc_q    <= resp_pc_d;
         resp_valid_q <= resp_valid_d;
         pend_pc_q    <= pend_pc_d;
         pend_valid_q <= pend_valid_d;
         instr_x_q    <= instr_x_d;
         pc_x_q       <= pc_x_d;
         valid_x_q    <= valid_x_d;
      end
   end
   // next state: any unstalled cycle runs; a stall parks RUN in STALL but leaves BOOT in BOOT
   always_comb begin
      state_d = !bus.stall ? RUN : (state_q == BOOT ? BOOT : STALL);
   end
   // datapath: advance on unstalled cycles; a live redirect beats a pending one and kills the wrong-path fetch
   always_comb begin
      redir        = bus.redirect_valid | pend_valid_q;
      tgt          = bus.redirect_valid ? (bus.redirect_pc & 32'hFFFF_FFFC) : pend_pc_q;
      fetch_pc_d   = bus.stall ? fetch_pc_q : (redir ? tgt : fetch_pc_q + 32'd4);
      resp_pc_d    = bus.stall ? resp_pc_q : fetch_pc_q;
      resp_valid_d = bus.stall ? resp_valid_q : ~redir;
      instr_x_d    = bus.stall ? instr_x_q : (resp_valid_q ? bus.imem_rdata : NOP_INSTR);
      pc_x_d       = bus.stall ? pc_x_q : resp_pc_q;
      valid_x_d    = bus.stall ? valid_x_q : resp_valid_q;
      pend_valid_d = bus.stall & (pend_valid_q | bus.redirect_valid);
      pend_pc_d    = (bus.stall & bus.redirect_valid) ? tgt : pend_pc_q;
   end
endmodule

// File: tb/tb_mips150_fetch_stage.sv
// tb_mips150_fetch_stage: directed stimulus against a stream-level model of the X-stage instruction sequence
module tb_mips150_fetch_stage;
   typedef struct {bit v; logic [31:0] pc;} ent_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [31:0] mem [0:4095];
   ent_t q[$];
   logic [31:0] tail_pc, ppc, m_pc;
   bit pend, m_valid;
   mips150_fetch_if #(.IMEM_AW(12)) bus ();
   mips150_fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(12), .NOP_INSTR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return {20'd0, pc[13:2]} + 32'd1;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic lit(input string name, input bit v, input logic [31:0] pc);
      chk({name, "_valid"}, {31'd0, bus.valid_x}, {31'd0, v});
      if (v) begin
         chk({name, "_pc"}, bus.pc_x, pc);
         chk({name, "_instr"}, bus.instr_x, ins_of(pc));
      end else chk({name, "_nop"}, bus.instr_x, 32'h0);
   endtask
   task automatic model_reset();
      q.delete();
      q.push_back('{1'b0, 32'h0});
      tail_pc = 32'h0;
      pend = 1'b0;
      m_valid = 1'b0;
      m_pc = 32'h0;
   endtask
   task automatic model_step(input bit st, input bit rv, input logic [31:0] rpc);
      ent_t e;
      if (st) begin
         if (rv) begin
            pend = 1'b1;
            ppc = rpc & ~32'd3;
         end
      end else begin
         if (q.size() == 0) begin
            q.push_back('{1'b1, tail_pc});
            tail_pc += 32'd4;
         end
         e = q.pop_front();
         m_valid = e.v;
         m_pc = e.pc;
         if (rv || pend) begin
            tail_pc = rv ? (rpc & ~32'd3) : ppc;
            q.delete();
            q.push_back('{1'b0, 32'h0});
            pend = 1'b0;
         end
      end
   endtask
   task automatic cyc(input bit st, input bit rv, input logic [31:0] rpc);
      bus.stall = st;
      bus.redirect_valid = rv;
      bus.redirect_pc = rpc;
      @(posedge clk);
      model_step(st, rv, rpc);
      #1;
   endtask
   initial begin
      forever begin
         @(negedge clk);
         chk("model_valid", {31'd0, bus.valid_x}, {31'd0, m_valid});
         if (m_valid) begin
            chk("model_pc", bus.pc_x, m_pc);
            chk("model_instr", bus.instr_x, ins_of(m_pc));
         end else chk("model_nop", bus.instr_x, 32'h0);
      end
   end
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = i + 1;
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.imem_rdata = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      lit("reset", 1'b0, 32'h0);
      chk("reset_pc_x", bus.pc_x, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("boot_addr", {20'd0, bus.imem_addr}, 32'h0);
      chk("run_en", {31'd0, bus.imem_en}, 32'd1);
      cyc(0, 0, 0); lit("boot_bubble", 1'b0, 0);
      cyc(0, 0, 0); lit("first", 1'b1, 32'h0);
      chk("first_instr_lit", bus.instr_x, 32'd1);
      chk("fetch_addr", {20'd0, bus.imem_addr}, 32'd2);
      cyc(0, 0, 0); lit("second", 1'b1, 32'h4);
      cyc(0, 0, 0); lit("third", 1'b1, 32'h8);
      chk("third_instr_lit", bus.instr_x, 32'd3);
      repeat (6) cyc(0, 0, 0);
      lit("at_20", 1'b1, 32'h20);
      cyc(0, 1, 32'h100); lit("br_slot", 1'b1, 32'h24);
      chk("br_slot_lit", bus.instr_x, 32'd10);
      cyc(0, 0, 0); lit("br_bubble", 1'b0, 0);
      cyc(0, 0, 0); lit("br_target", 1'b1, 32'h100);
      chk("br_target_lit", bus.instr_x, 32'h41);
      repeat (4) cyc(0, 0, 0);
      lit("at_110", 1'b1, 32'h110);
      bus.stall = 1'b1;
      #1;
      chk("stall_en", {31'd0, bus.imem_en}, 32'd0);
      repeat (3) cyc(1, 0, 0);
      lit("stall_hold", 1'b1, 32'h110);
      cyc(0, 0, 0); lit("stall_release", 1'b1, 32'h114);
      chk("release_en", {31'd0, bus.imem_en}, 32'd1);
      cyc(0, 0, 0); lit("after_release", 1'b1, 32'h118);
      cyc(1, 1, 32'h200);
      cyc(1, 0, 0); lit("pend_hold", 1'b1, 32'h118);
      cyc(0, 0, 0); lit("pend_slot", 1'b1, 32'h11c);
      cyc(0, 0, 0); lit("pend_bubble", 1'b0, 0);
      cyc(0, 0, 0); lit("pend_target", 1'b1, 32'h200);
      cyc(0, 0, 0); lit("pend_cleared", 1'b1, 32'h204);
      cyc(1, 1, 32'h300);
      cyc(1, 0, 0);
      cyc(1, 1, 32'h401);
      cyc(0, 0, 0); lit("dbl_slot", 1'b1, 32'h208);
      cyc(0, 0, 0); lit("dbl_bubble", 1'b0, 0);
      cyc(0, 0, 0); lit("dbl_target", 1'b1, 32'h400);
      chk("dbl_target_lit", bus.instr_x, 32'h101);
      cyc(0, 0, 0); lit("dbl_next", 1'b1, 32'h404);
      cyc(1, 1, 32'h500);
      cyc(0, 1, 32'h600); lit("win_slot", 1'b1, 32'h408);
      cyc(0, 0, 0); lit("win_bubble", 1'b0, 0);
      cyc(0, 0, 0); lit("win_target", 1'b1, 32'h600);
      cyc(0, 0, 0); lit("win_next", 1'b1, 32'h604);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      lit("async_rst", 1'b0, 0);
      chk("async_rst_pc", bus.pc_x, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(0, 0, 0); lit("re_bubble", 1'b0, 0);
      cyc(0, 0, 0); lit("re_first", 1'b1, 32'h0);
      cyc(0, 0, 0); lit("re_second", 1'b1, 32'h4);
      cyc(0, 0, 0); lit("re_third", 1'b1, 32'h8);
      repeat (3) cyc(0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
